crot_pi_k_gate_pipelined: RTL and testbench
===========================================

Name: crot_pi_k_gate_pipelined

Overview:
Parametrised controlled-phase rotation gate. It multiplies a complex amplitude (ar + j·ai) by e^(jθ), where θ = π/2^k and k is selected per sample. When the control bit is 0 the amplitude passes through unchanged with identical latency. It generalises the fixed π/4 rotator into one block for every QFT stage, with a ready/valid handshake, per-stage backpressure and output saturation.

Parameters:
TOTAL_WIDTH, 8, signed data width of ar/ai/pr/pi (S.FRAC fixed point)
FRAC_WIDTH, 4, fractional bits of data and coefficients
K_MAX, 3, largest supported k (θ = π/2^K_MAX); legal range 0..7
K_WIDTH, 3, width of in_k

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  input sample valid
in_ready  out  1  block accepts sample this cycle
in_ctrl  in  1  control qubit bit; 0 = identity
in_k  in  K_WIDTH  rotation index
in_ar  in  TOTAL_WIDTH  real part, signed
in_ai  in  TOTAL_WIDTH  imaginary part, signed
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts output
out_pr  out  TOTAL_WIDTH  rotated real part
out_pi  out  TOTAL_WIDTH  rotated imaginary part
out_err  out  1  sample had in_k > K_MAX (aligned with out_valid)

Behaviour:
- Single clock. Reset is synchronous and active-high: on any clk edge with rst=1, all stage valid bits clear and all data registers go to 0.
- Reset values: out_valid=0, out_pr=0, out_pi=0, out_err=0. in_ready is forced 0 while rst=1 and is 1 on the first cycle after reset.
- Transfer occurs on a clk edge when valid and ready are both 1, on either side.
- Four registered stages, each with its own valid bit. Latency is 4 cycles from input acceptance to out_valid when there is no stall.
- Stage n loads when it is empty or when its content moves on this cycle (bubble-collapsing pipeline). The last stage moves when out_ready=1.
- in_ready = !v1 || stage1 moves. This is combinational from state and out_ready; there is no combinational path from in_valid.
- S1: register ar/ai. Look up coefficients C = round(cos θ·2^FRAC) and S = round(sin θ·2^FRAC) from a constant table.
  - If in_ctrl=0 or in_k > K_MAX, use C = 2^FRAC and S = 0.
  - err = (in_k > K_MAX), regardless of in_ctrl.
- Coefficient width is FRAC_WIDTH+2 (signed, holds ±1.0). Defaults: k0 (-16,0), k1 (0,16), k2 (11,11), k3 (15,6).
- S2: four products ar·C, ai·S, ar·S, ai·C. Each product is TOTAL_WIDTH+FRAC_WIDTH+2 bits, full precision.
- S3: re = ar·C − ai·S and im = ar·S + ai·C, each one bit wider than the products.
- S4: arithmetic shift right by FRAC_WIDTH (see the optional feature for rounding), then saturate to [−2^(TOTAL_WIDTH−1), 2^(TOTAL_WIDTH−1)−1].
- Identity path is bit-exact: out equals in for every input value.
- Stalled stages hold data and valid unchanged. There is no drop, duplication or reordering.
- Data registers of empty stages may hold stale values; out_pr/out_pi are don't-care while out_valid=0.
- rst asserted mid-stream flushes every in-flight sample. No output appears for those samples.

Optional Feature:
ROUND_EN
- Defined: S4 adds 2^(FRAC_WIDTH−1) before the shift (round-half-up toward +∞), then saturates.
- Undefined: plain arithmetic-shift truncation toward −∞, matching the existing fixed rotators.
- Latency and handshake are identical in both builds.

Decomposition:
- Extend the shared fixed_point_params include/package with:
  - COEF_WIDTH = FRAC_WIDTH+2
  - a constant function returning (C,S) for k in 0..7 at the given FRAC_WIDTH
  - a saturate function
- One sub-module is natural: crot_pipe_stage_ctrl, a per-stage valid/advance cell instantiated four times.
- Arithmetic stays inline in the top module.

Test Plan:
- Default params, truncate build, ctrl=1, k=1, ar=16, ai=32 -> after 4 cycles pr=−32, pi=16, err=0.
- k=3, ar=ai=16 -> pr=9, pi=21 (both builds). k=2, ar=1, ai=0 -> truncate pr=0, pi=0; ROUND_EN pr=1, pi=1.
- k=0, ar=−128, ai=0 -> pr=127 (saturated), pi=0. ctrl=0 with ar=−128, ai=127 under any k -> pr=−128, pi=127.
- k=5 (>K_MAX), ar=40, ai=−7 -> pr=40, pi=−7, out_err=1. Next sample k=2 -> out_err=0.
- Back-to-back stream of 10 random samples; hold out_ready=0 for 6 cycles mid-stream.
  - in_ready must drop once 4 samples are resident.
  - Outputs must match the golden model in order with no loss or duplication.
  - Full throughput (1 sample/cycle) must resume when out_ready returns to 1.
- Assert rst for 1 cycle with 3 samples in flight -> out_valid=0 and out_pr/pi/err=0 next cycle, no stale outputs later, in_ready=1 after release.

Source files
------------

// File: rtl/crot_pi_k_gate_pipelined_pkg.sv
// Shared fixed-point helpers for the controlled pi/2^k rotator: coefficient
// width, the rotation coefficient table and signed saturation.
package crot_pi_k_gate_pipelined_pkg;

  localparam int FRAC_WIDTH_DEF = 4;
  localparam int COEF_WIDTH     = FRAC_WIDTH_DEF + 2;

  typedef struct packed {
    logic signed [31:0] c;
    logic signed [31:0] s;
  } coef_t;

  // cos/sin(pi/2^k) held at 16 fractional bits, rounded half-up to frac bits
  function automatic coef_t crot_coef(input int k, input int frac);
    logic signed [31:0] c16, s16;
    coef_t r;
    case (k)
      0:       begin c16 = -32'sd65536; s16 = 32'sd0;     end
      1:       begin c16 = 32'sd0;      s16 = 32'sd65536; end
      2:       begin c16 = 32'sd46341;  s16 = 32'sd46341; end
      3:       begin c16 = 32'sd60547;  s16 = 32'sd25080; end
      4:       begin c16 = 32'sd64277;  s16 = 32'sd12785; end
      5:       begin c16 = 32'sd65220;  s16 = 32'sd6424;  end
      6:       begin c16 = 32'sd65457;  s16 = 32'sd3216;  end
      default: begin c16 = 32'sd65516;  s16 = 32'sd1608;  end
    endcase
    r.c = (c16 + (32'sd1 <<< (15 - frac))) >>> (16 - frac);
    r.s = (s16 + (32'sd1 <<< (15 - frac))) >>> (16 - frac);
    return r;
  endfunction

  function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/crot_pipe_stage_ctrl.sv
// Valid/advance cell for one stage of a bubble-collapsing pipeline.
module crot_pipe_stage_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic up_valid_i,
  input  logic down_ready_i,
  output logic valid_o,
  output logic ready_o,
  output logic load_o
);

  logic valid_q, valid_d;

  always_comb begin
    ready_o = !valid_q || down_ready_i;
    load_o  = ready_o && up_valid_i;
    valid_d = ready_o ? up_valid_i : valid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  assign valid_o = valid_q;

endmodule

// File: rtl/crot_pi_k_gate_pipelined.sv
// Four-stage controlled e^(j*pi/2^k) rotator with ready/valid and saturation.
// Optional macro ROUND_EN: round half-up before the final shift.
module crot_pi_k_gate_pipelined
  import crot_pi_k_gate_pipelined_pkg::*;
#(
  parameter int TOTAL_WIDTH = 8,
  parameter int FRAC_WIDTH  = 4,
  parameter int K_MAX       = 3,
  parameter int K_WIDTH     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_ctrl,
  input  logic [K_WIDTH-1:0]     in_k,
  input  logic [TOTAL_WIDTH-1:0] in_ar,
  input  logic [TOTAL_WIDTH-1:0] in_ai,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TOTAL_WIDTH-1:0] out_pr,
  output logic [TOTAL_WIDTH-1:0] out_pi,
  output logic                   out_err
);

  localparam int COEF_W = FRAC_WIDTH + 2;
  localparam int P      = TOTAL_WIDTH + COEF_W;
  localparam int STAGES = 4;

  logic [STAGES:0]   vld_pipe;
  logic [STAGES:0]   rdy_pipe;
  logic [STAGES-1:0] ld;

  assign vld_pipe[0]      = in_valid;
  assign rdy_pipe[STAGES] = out_ready;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    crot_pipe_stage_ctrl u_ctrl (
      .clk          (clk),
      .rst          (rst),
      .up_valid_i   (vld_pipe[g]),
      .down_ready_i (rdy_pipe[g+1]),
      .valid_o      (vld_pipe[g+1]),
      .ready_o      (rdy_pipe[g]),
      .load_o       (ld[g])
    );
  end

  assign in_ready  = rdy_pipe[0] && !rst;
  assign out_valid = vld_pipe[STAGES];

  logic signed [TOTAL_WIDTH-1:0] ar1_q, ai1_q;
  logic signed [COEF_W-1:0]      c1_q, s1_q, c1_d, s1_d;
  logic                          err1_q, err2_q, err3_q, err4_q, k_bad;
  logic signed [P-1:0]           p_arc_q, p_ais_q, p_ars_q, p_aic_q;
  logic signed [P:0]             re3_q, im3_q;
  logic signed [P+1:0]           re_w, im_w, re_sh, im_sh;
  logic signed [TOTAL_WIDTH-1:0] pr4_q, pi4_q, pr4_d, pi4_d;
  coef_t                         co;

  // Identity and out-of-range k both fall back to C = 1.0, S = 0
  always_comb begin
    k_bad = int'(in_k) > K_MAX;
    co    = crot_coef(int'(in_k), FRAC_WIDTH);
    c1_d  = COEF_W'(co.c);
    s1_d  = COEF_W'(co.s);
    if (!in_ctrl || k_bad) begin
      c1_d = COEF_W'(1 << FRAC_WIDTH);
      s1_d = '0;
    end
  end

`ifdef ROUND_EN
  localparam logic signed [P+1:0] HALF = (P+2)'(1) <<< (FRAC_WIDTH - 1);
  assign re_w = (P+2)'(re3_q) + HALF;
  assign im_w = (P+2)'(im3_q) + HALF;
`else
  assign re_w = (P+2)'(re3_q);
  assign im_w = (P+2)'(im3_q);
`endif

  always_comb begin
    re_sh = re_w >>> FRAC_WIDTH;
    im_sh = im_w >>> FRAC_WIDTH;
    pr4_d = TOTAL_WIDTH'(sat_s(64'(re_sh), TOTAL_WIDTH));
    pi4_d = TOTAL_WIDTH'(sat_s(64'(im_sh), TOTAL_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar1_q   <= '0;
      ai1_q   <= '0;
      c1_q    <= '0;
      s1_q    <= '0;
      err1_q  <= 1'b0;
      p_arc_q <= '0;
      p_ais_q <= '0;
      p_ars_q <= '0;
      p_aic_q <= '0;
      err2_q  <= 1'b0;
      re3_q   <= '0;
      im3_q   <= '0;
      err3_q  <= 1'b0;
      pr4_q   <= '0;
      pi4_q   <= '0;
      err4_q  <= 1'b0;
    end else begin
      if (ld[0]) begin
        ar1_q  <= in_ar;
        ai1_q  <= in_ai;
        c1_q   <= c1_d;
        s1_q   <= s1_d;
        err1_q <= k_bad;
      end
      if (ld[1]) begin
        p_arc_q <= ar1_q * c1_q;
        p_ais_q <= ai1_q * s1_q;
        p_ars_q <= ar1_q * s1_q;
        p_aic_q <= ai1_q * c1_q;
        err2_q  <= err1_q;
      end
      if (ld[2]) begin
        re3_q  <= (P+1)'(p_arc_q) - (P+1)'(p_ais_q);
        im3_q  <= (P+1)'(p_ars_q) + (P+1)'(p_aic_q);
        err3_q <= err2_q;
      end
      if (ld[3]) begin
        pr4_q  <= pr4_d;
        pi4_q  <= pi4_d;
        err4_q <= err3_q;
      end
    end
  end

  assign out_pr  = pr4_q;
  assign out_pi  = pi4_q;
  assign out_err = err4_q;

endmodule

// File: tb/tb_crot_pi_k_gate_pipelined.sv
// Scoreboard bench for crot_pi_k_gate_pipelined: driver pushes model results,
// monitor pops and compares on each output handshake.
module tb_crot_pi_k_gate_pipelined;

  localparam int TW = 8;
  localparam int FW = 4;
  localparam int KM = 3;
  localparam int KW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_ctrl;
  logic [KW-1:0] in_k;
  logic [TW-1:0] in_ar, in_ai;
  logic          out_valid, out_ready;
  logic [TW-1:0] out_pr, out_pi;
  logic          out_err;

  always #5 clk = ~clk;

  crot_pi_k_gate_pipelined #(
    .TOTAL_WIDTH(TW), .FRAC_WIDTH(FW), .K_MAX(KM), .K_WIDTH(KW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_k(in_k),
    .in_ar(in_ar), .in_ai(in_ai),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pr(out_pr), .out_pi(out_pi), .out_err(out_err)
  );

  typedef struct {
    int pr;
    int pi;
    bit err;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   inflight = 0;
  bit   saw_full = 0;

  // Reference: rotate by the rounded Q.4 coefficients, scale down, clip to 8 bits
  function automatic exp_t model(bit ctrl, int k, int ar, int ai);
    exp_t e;
    int   c, s, re, im;
    c = 16; s = 0;
    if (ctrl && k <= KM) begin
      case (k)
        0: begin c = -16; s = 0;  end
        1: begin c = 0;   s = 16; end
        2: begin c = 11;  s = 11; end
        default: begin c = 15; s = 6; end
      endcase
    end
    re = ar * c - ai * s;
    im = ar * s + ai * c;
`ifdef ROUND_EN
    re = re + 8;
    im = im + 8;
`endif
    re = re >>> 4;
    im = im >>> 4;
    e.pr  = (re > 127) ? 127 : (re < -128) ? -128 : re;
    e.pi  = (im > 127) ? 127 : (im < -128) ? -128 : im;
    e.err = (k > KM);
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got pr=%0d pi=%0d with no sample expected at %0t",
                 $signed(out_pr), $signed(out_pi), $time);
      end else begin
        e = q.pop_front();
        check("out_pr", int'($signed(out_pr)), e.pr);
        check("out_pi", int'($signed(out_pi)), e.pi);
        check("out_err", int'(out_err), int'(e.err));
      end
    end
  end

  // Pipe holds at most four samples; input is refused only when full and stalled
  always @(posedge clk) begin
    if (rst) inflight <= 0;
    else inflight <= inflight + int'(in_valid && in_ready) - int'(out_valid && out_ready);
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", int'(in_ready), int'((inflight < 4) || out_ready));
      if (!in_ready) saw_full = 1'b1;
    end
  end

  task automatic drive(input bit ctrl, input int k, input int ar, input int ai);
    int n = 0;
    in_valid = 1'b1;
    in_ctrl  = ctrl;
    in_k     = KW'(k);
    in_ar    = TW'(ar);
    in_ai    = TW'(ai);
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
    end else begin
      q.push_back(model(ctrl, k, ar, ai));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drained", q.size(), 0);
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; in_ctrl = 1'b0; in_k = '0;
    in_ar = '0; in_ai = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_pr", int'($signed(out_pr)), 0);
    check("rst_out_pi", int'($signed(out_pi)), 0);
    check("rst_out_err", int'(out_err), 0);
    check("rst_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);

    drive(1, 1, 16, 32);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 4);
    idle(2);

    drive(1, 3, 16, 16);
    drive(1, 2, 1, 0);
    drive(1, 0, -128, 0);
    for (int k = 0; k < 8; k++) drive(0, k, -128, 127);
    drive(1, 5, 40, -7);
    drive(1, 2, 40, -7);
    drain();

    saw_full = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          drive($urandom_range(0, 1), $urandom_range(0, 7),
                int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("in_ready_dropped", int'(saw_full), 1);

    fork
      begin
        for (int i = 0; i < 40; i++) begin
          drive($urandom_range(0, 3) != 0, $urandom_range(0, 7),
                int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
          if ($urandom_range(0, 4) == 0) idle(1);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (120) begin
          out_ready = $urandom_range(0, 1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    out_ready = 1'b1;
    drive(1, 1, 16, 32);
    drive(1, 3, 16, 16);
    drive(0, 2, 5, 6);
    rst = 1'b1;
    in_valid = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    check("flush_out_valid", int'(out_valid), 0);
    check("flush_out_pr", int'($signed(out_pr)), 0);
    check("flush_out_pi", int'($signed(out_pi)), 0);
    check("flush_out_err", int'(out_err), 0);
    check("flush_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    #1;
    check("flush_release_in_ready", int'(in_ready), 1);
    idle(10);
    drive(1, 1, 16, 32);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
